// File: rtl/bcp_scheduler.sv
// bcp_scheduler: Boolean constraint propagation over one bin of clauses.
// Clauses are scanned one per cycle against a working assignment. A unit
// clause forces its free literal; an unsatisfiable clause ends the run in
// conflict. Scanning repeats while passes keep producing implications.
// Optional feature macro: BCP_IMP_COUNT_EN adds imp_cnt_o, an 8-bit
// saturating count of implications made during the last run.
module bcp_scheduler #(
    parameter int NUM_VARS_A_BIN    = 8,
    parameter int NUM_CLAUSES_A_BIN = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_clause_i,
    input  logic [$clog2(NUM_CLAUSES_A_BIN)-1:0] clause_addr_i,
    input  logic [NUM_VARS_A_BIN*2-1:0]          clause_lits_i,
    input  logic [$clog2(NUM_CLAUSES_A_BIN):0]   num_clauses_i,
    input  logic                                 start_i,
    input  logic [NUM_VARS_A_BIN*3-1:0]          var_value_i,
    output logic [NUM_VARS_A_BIN*3-1:0]          var_value_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 conflict_o,
    output logic [$clog2(NUM_CLAUSES_A_BIN)-1:0] conflict_idx_o
`ifdef BCP_IMP_COUNT_EN
    ,
    output logic [7:0]                           imp_cnt_o
`endif
);

    localparam int AW = $clog2(NUM_CLAUSES_A_BIN);
    localparam int CW = AW + 1;
    localparam int VW = (NUM_VARS_A_BIN > 1) ? $clog2(NUM_VARS_A_BIN) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                      state;
    logic [NUM_VARS_A_BIN*2-1:0] mem [NUM_CLAUSES_A_BIN];
    logic [AW-1:0]               idx;
    logic [CW-1:0]               num_q;
    logic                        changed;

    logic                        sat;
    logic [1:0]                  free_cnt;
    logic [VW-1:0]               free_var;
    logic [1:0]                  free_lit;
    logic                        imp;
    logic                        last;

    // Evaluate clause[idx] against the working assignment: satisfied flag,
    // free-literal count (saturating at 2) and the free literal itself.
    always_comb begin
        logic [NUM_VARS_A_BIN*2-1:0] clause;
        logic [1:0]                  lit;
        logic [1:0]                  val;
        sat      = 1'b0;
        free_cnt = 2'd0;
        free_var = '0;
        free_lit = 2'b00;
        clause   = mem[idx];
        for (int unsigned i = 0; i < NUM_VARS_A_BIN; i++) begin
            lit = clause[2*i +: 2];
            val = var_value_o[3*i +: 2];
            if (lit == 2'b01 || lit == 2'b10) begin
                if (val == lit) begin
                    sat = 1'b1;
                end else if (val == 2'b00) begin
                    if (free_cnt != 2'd2) free_cnt = free_cnt + 2'd1;
                    free_var = VW'(i);
                    free_lit = lit;
                end
            end
        end
        imp  = !sat && (free_cnt == 2'd1);
        last = ({1'b0, idx} == (num_q - CW'(1)));
    end

    // Clause memory writes and the IDLE/SCAN/DONE controller with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            var_value_o    <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            conflict_o     <= 1'b0;
            conflict_idx_o <= '0;
            idx            <= '0;
            num_q          <= '0;
            changed        <= 1'b0;
            for (int unsigned i = 0; i < NUM_CLAUSES_A_BIN; i++) mem[i] <= '0;
`ifdef BCP_IMP_COUNT_EN
            imp_cnt_o      <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            if (state == IDLE && wr_clause_i &&
                (int'(clause_addr_i) < NUM_CLAUSES_A_BIN))
                mem[clause_addr_i] <= clause_lits_i;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        var_value_o <= var_value_i;
                        num_q       <= num_clauses_i;
                        idx         <= '0;
                        changed     <= 1'b0;
                        conflict_o  <= 1'b0;
                        busy_o      <= 1'b1;
`ifdef BCP_IMP_COUNT_EN
                        imp_cnt_o   <= '0;
`endif
                        if (num_clauses_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (!sat && free_cnt == 2'd0) begin
                        conflict_o     <= 1'b1;
                        conflict_idx_o <= idx;
                        state          <= DONE;
                        done_o         <= 1'b1;
                    end else begin
                        if (imp) begin
                            var_value_o[3*free_var +: 3] <= {1'b1, free_lit};
`ifdef BCP_IMP_COUNT_EN
                            if (imp_cnt_o != 8'hFF) imp_cnt_o <= imp_cnt_o + 8'd1;
`endif
                        end
                        if (last) begin
                            // Another pass is needed if anything changed, this cycle included.
                            if (changed || imp) begin
                                idx     <= '0;
                                changed <= 1'b0;
                            end else begin
                                state  <= DONE;
                                done_o <= 1'b1;
                            end
                        end else begin
                            idx     <= idx + AW'(1);
                            changed <= changed | imp;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcp_scheduler.sv
// Directed testbench for bcp_scheduler with hand-computed expectations.
// Define BCP_IMP_COUNT_EN to also connect and check imp_cnt_o.
module tb_bcp_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_clause_i;
    logic [3:0]  clause_addr_i;
    logic [15:0] clause_lits_i;
    logic [4:0]  num_clauses_i;
    logic        start_i;
    logic [23:0] var_value_i;
    logic [23:0] var_value_o;
    logic        busy_o;
    logic        done_o;
    logic        conflict_o;
    logic [3:0]  conflict_idx_o;
`ifdef BCP_IMP_COUNT_EN
    logic [7:0]  imp_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    bcp_scheduler #(.NUM_VARS_A_BIN(8), .NUM_CLAUSES_A_BIN(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_clause_i    (wr_clause_i),
        .clause_addr_i  (clause_addr_i),
        .clause_lits_i  (clause_lits_i),
        .num_clauses_i  (num_clauses_i),
        .start_i        (start_i),
        .var_value_i    (var_value_i),
        .var_value_o    (var_value_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .conflict_o     (conflict_o),
        .conflict_idx_o (conflict_idx_o)
`ifdef BCP_IMP_COUNT_EN
        ,
        .imp_cnt_o      (imp_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lit(input int v, input logic [1:0] pol);
        return 16'(pol) << (2 * v);
    endfunction

    function automatic logic [23:0] vv(input int v, input logic [2:0] x);
        return 24'(x) << (3 * v);
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_clause(input logic [3:0] a, input logic [15:0] l);
        wr_clause_i   = 1'b1;
        clause_addr_i = a;
        clause_lits_i = l;
        tick();
        wr_clause_i   = 1'b0;
    endtask

    // Start a run and measure edges from the start-sampling edge to done_o.
    task automatic do_run(input logic [4:0] n, input int exp_edges, input string tag);
        int edges;
        logic seen;
        num_clauses_i = n;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wr_clause_i = 1'b0;
        edges = 0;
        seen = done_o;
        while (!seen && edges < 200) begin
            tick();
            edges++;
            seen = done_o;
        end
        chk(32'(edges), 32'(exp_edges), {tag, "_latency"});
        tick();
        chk({31'b0, done_o}, 32'd0, {tag, "_done_pulse"});
        chk({31'b0, busy_o}, 32'd0, {tag, "_idle_after"});
    endtask

    initial begin
        int dcnt;
        int first;

        rst = 1'b1; wr_clause_i = 1'b0; clause_addr_i = '0; clause_lits_i = '0;
        num_clauses_i = '0; start_i = 1'b0; var_value_i = '0;
        tick(); tick();
        rst = 1'b0;
        chk(32'(var_value_o), 32'd0, "rst_var");
        chk({31'b0, busy_o}, 32'd0, "rst_busy");
        chk({31'b0, done_o}, 32'd0, "rst_done");
        chk({31'b0, conflict_o}, 32'd0, "rst_conflict");
        chk(32'(conflict_idx_o), 32'd0, "rst_cidx");

        // Clause (v1+ v3- v5-), all free: nothing to do, one pass.
        write_clause(4'd0, lit(1, 2'b01) | lit(3, 2'b10) | lit(5, 2'b10));
        var_value_i = '0;
        do_run(5'd1, 1, "t1");
        chk({31'b0, conflict_o}, 32'd0, "t1_conflict");
        chk(32'(var_value_o), 32'd0, "t1_var");

        // v1 false, v5 true: v3 forced false, second pass confirms.
        var_value_i = vv(1, 3'b010) | vv(5, 3'b001);
        do_run(5'd1, 2, "t2");
        chk(32'(var_value_o), 32'(vv(1, 3'b010) | vv(5, 3'b001) | vv(3, 3'b110)), "t2_var");
        chk({31'b0, conflict_o}, 32'd0, "t2_conflict");
`ifdef BCP_IMP_COUNT_EN
        chk(32'(imp_cnt_o), 32'd1, "t2_impcnt");
`endif

        // Implication chain across three clauses.
        write_clause(4'd0, lit(0, 2'b01));
        write_clause(4'd1, lit(0, 2'b10) | lit(1, 2'b01));
        write_clause(4'd2, lit(1, 2'b10) | lit(2, 2'b10));
        var_value_i = '0;
        do_run(5'd3, 6, "t3");
        chk(32'(var_value_o), 32'(vv(0, 3'b101) | vv(1, 3'b101) | vv(2, 3'b110)), "t3_var");
        chk({31'b0, conflict_o}, 32'd0, "t3_conflict");
`ifdef BCP_IMP_COUNT_EN
        chk(32'(imp_cnt_o), 32'd3, "t3_impcnt");
`endif

        // (v0+) then (v0-): conflict on clause 1.
        write_clause(4'd1, lit(0, 2'b10));
        do_run(5'd2, 2, "t4");
        chk({31'b0, conflict_o}, 32'd1, "t4_conflict");
        chk(32'(conflict_idx_o), 32'd1, "t4_cidx");
        tick(); tick();
        chk({31'b0, conflict_o}, 32'd1, "t4_conflict_held");

        // Zero clauses: straight to DONE, conflict cleared, assignment latched.
        var_value_i = vv(4, 3'b001);
        do_run(5'd0, 0, "t5");
        chk({31'b0, conflict_o}, 32'd0, "t5_conflict_cleared");
        chk(32'(var_value_o), 32'(vv(4, 3'b001)), "t5_var");

        // Reset in the middle of a 16-clause scan.
        for (int i = 0; i < 16; i++) write_clause(4'(i), lit(0, 2'b01) | lit(1, 2'b01));
        var_value_i = vv(6, 3'b010);
        num_clauses_i = 5'd16;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk({31'b0, busy_o}, 32'd1, "t6_busy_mid");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk({31'b0, busy_o}, 32'd0, "t6_busy_rst");
        chk(32'(var_value_o), 32'd0, "t6_var_rst");
        dcnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (done_o) dcnt++;
            tick();
        end
        chk(32'(dcnt), 32'd0, "t6_no_done");

        // Reset cleared clause memory: empty clause 0 is a conflict.
        var_value_i = '0;
        do_run(5'd1, 1, "t7");
        chk({31'b0, conflict_o}, 32'd1, "t7_conflict");
        chk(32'(conflict_idx_o), 32'd0, "t7_cidx");

        // Write and start together: run sees (v2-), forces v2 false.
        wr_clause_i = 1'b1; clause_addr_i = 4'd0; clause_lits_i = lit(2, 2'b10);
        do_run(5'd1, 2, "t8");
        chk({31'b0, conflict_o}, 32'd0, "t8_conflict");
        chk(32'(var_value_o), 32'(vv(2, 3'b110)), "t8_var");

        // Start and write while busy are both ignored.
        for (int i = 0; i < 16; i++) write_clause(4'(i), lit(0, 2'b01) | lit(1, 2'b01));
        var_value_i = '0;
        num_clauses_i = 5'd16;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        dcnt = 0;
        first = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done_o) begin
                dcnt++;
                if (first == 0) first = k;
            end
            if (k == 3) begin
                start_i = 1'b1; wr_clause_i = 1'b1;
                clause_addr_i = 4'd0; clause_lits_i = '0;
            end else begin
                start_i = 1'b0; wr_clause_i = 1'b0;
            end
        end
        chk(32'(dcnt), 32'd1, "t9_one_done");
        chk(32'(first), 32'd16, "t9_latency");
        do_run(5'd1, 1, "t9b");
        chk({31'b0, conflict_o}, 32'd0, "t9_write_dropped");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
